// File: rtl/jk_mod_counter_pkg.sv
// -----------------------------------------------------------------------------
// jk_pkg : shared definitions for the JK modulo counter.
//   jk_cmd_t    2-bit per-bit command {J,K}
//   JK_HOLD/CLR/SET/TGL command encodings
//   jk_target() maps a desired bit value to the set/clear command that
//               forces the cell to that value regardless of its current state
// -----------------------------------------------------------------------------
package jk_pkg;

    typedef logic [1:0] jk_cmd_t;

    localparam jk_cmd_t JK_HOLD = 2'b00;
    localparam jk_cmd_t JK_CLR  = 2'b01;
    localparam jk_cmd_t JK_SET  = 2'b10;
    localparam jk_cmd_t JK_TGL  = 2'b11;

    function automatic jk_cmd_t jk_target(input logic b);
        return b ? JK_SET : JK_CLR;
    endfunction

endpackage

// File: rtl/jk_cell.sv
// -----------------------------------------------------------------------------
// jk_cell : single-bit JK storage element.
//   CLK    rising-edge clock
//   RST    asynchronous active-high reset (o_q -> 0)
//   i_cmd  {J,K}: 00 hold, 01 clear, 10 set, 11 toggle
//   o_q    stored bit
// -----------------------------------------------------------------------------
module jk_cell
    import jk_pkg::*;
(
    input  logic    CLK,
    input  logic    RST,
    input  jk_cmd_t i_cmd,
    output logic    o_q
);

    logic r_q;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_q <= 1'b0;
        end else begin
            case (i_cmd)
                JK_CLR:  r_q <= 1'b0;
                JK_SET:  r_q <= 1'b1;
                JK_TGL:  r_q <= ~r_q;
                default: r_q <= r_q;
            endcase
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/jk_mod_counter.sv
// -----------------------------------------------------------------------------
// jk_mod_counter : modulo-MOD up/down counter built from W jk_cell instances.
//   CLK   rising-edge clock
//   RST   asynchronous active-high reset (Q=0, WRAP=0)
//   EN    count enable
//   UP    direction, 1 = increment, 0 = decrement
//   LOAD  synchronous load of D (clamped to MOD-1), beats EN
//   D     load value
//   Q     registered count, always < MOD
//   TC    combinational terminal count for the current direction
//   WRAP  registered pulse in the cycle after a wrap
//   SAT   (only with JK_MOD_COUNTER_SAT_EN) registered saturation flag
// Build option: define JK_MOD_COUNTER_SAT_EN to saturate at the terminal count
// instead of wrapping; WRAP then stays 0 and the SAT port is added.
// -----------------------------------------------------------------------------
module jk_mod_counter
    import jk_pkg::*;
#(
    parameter int W   = 4,
    parameter int MOD = 10
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         EN,
    input  logic         UP,
    input  logic         LOAD,
    input  logic [W-1:0] D,
    output logic [W-1:0] Q,
    output logic         TC,
`ifdef JK_MOD_COUNTER_SAT_EN
    output logic         SAT,
`endif
    output logic         WRAP
);

    localparam logic [W:0]   C_MOD = (W+1)'(MOD);
    localparam logic [W-1:0] C_MAX = W'(MOD - 1);

    logic [W-1:0]      w_ld;
    logic [W-1:0]      w_ones;   // w_ones[i]:  all bits below i are 1
    logic [W-1:0]      w_zeros;  // w_zeros[i]: all bits below i are 0
    logic [W-1:0][1:0] w_cmd;
    logic              r_wrap;

    // Clamp keeps Q in range, so the counter can never leave 0..MOD-1.
    assign w_ld = ({1'b0, D} >= C_MOD) ? C_MAX : D;

    assign TC = UP ? (Q == C_MAX) : (Q == '0);

    // Ripple-carry / ripple-borrow enables for the toggle chain.
    assign w_ones[0]  = 1'b1;
    assign w_zeros[0] = 1'b1;
    for (genvar i = 1; i < W; i++) begin : g_chain
        assign w_ones[i]  = w_ones[i-1]  &  Q[i-1];
        assign w_zeros[i] = w_zeros[i-1] & ~Q[i-1];
    end

    always_comb begin
        for (int i = 0; i < W; i++) begin
            w_cmd[i] = JK_HOLD;
            if (LOAD) begin
                w_cmd[i] = jk_target(w_ld[i]);
            end else if (EN) begin
                if (TC) begin
`ifdef JK_MOD_COUNTER_SAT_EN
                    w_cmd[i] = JK_HOLD;
`else
                    // Wrap is an explicit forced value, not a toggle, so it
                    // also works when MOD is not a power of two.
                    w_cmd[i] = UP ? JK_CLR : jk_target(C_MAX[i]);
`endif
                end else if (UP ? w_ones[i] : w_zeros[i]) begin
                    w_cmd[i] = JK_TGL;
                end
            end
        end
    end

    for (genvar i = 0; i < W; i++) begin : g_bit
        jk_cell u_cell (
            .CLK   (CLK),
            .RST   (RST),
            .i_cmd (w_cmd[i]),
            .o_q   (Q[i])
        );
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_wrap <= 1'b0;
        end else begin
`ifdef JK_MOD_COUNTER_SAT_EN
            r_wrap <= 1'b0;
`else
            r_wrap <= ~LOAD & EN & TC;
`endif
        end
    end

    assign WRAP = r_wrap;

`ifdef JK_MOD_COUNTER_SAT_EN
    logic r_sat;

    // While saturated Q sits at the terminal value of the direction that
    // saturated it, so any count that is not at TC is an opposite-direction
    // count and releases the flag.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_sat <= 1'b0;
        end else if (LOAD) begin
            r_sat <= 1'b0;
        end else if (EN) begin
            r_sat <= TC;
        end
    end

    assign SAT = r_sat;
`endif

endmodule

// File: tb/tb_jk_mod_counter.sv
module tb_jk_mod_counter;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       EN = 1'b0, UP = 1'b1, LOAD = 1'b0;
    logic [3:0] D = '0;
    logic [3:0] Q;
    logic       TC, WRAP;

    // second instance: power-of-two modulus boundary
    logic       EN2 = 1'b0, UP2 = 1'b1, LOAD2 = 1'b0;
    logic [2:0] D2 = '0;
    logic [2:0] Q2;
    logic       TC2, WRAP2;

`ifdef JK_MOD_COUNTER_SAT_EN
    logic SAT, SAT2;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    jk_mod_counter #(.W(4), .MOD(10)) dut (
        .CLK(CLK), .RST(RST), .EN(EN), .UP(UP), .LOAD(LOAD), .D(D),
        .Q(Q), .TC(TC),
`ifdef JK_MOD_COUNTER_SAT_EN
        .SAT(SAT),
`endif
        .WRAP(WRAP)
    );

    jk_mod_counter #(.W(3), .MOD(8)) dut2 (
        .CLK(CLK), .RST(RST), .EN(EN2), .UP(UP2), .LOAD(LOAD2), .D(D2),
        .Q(Q2), .TC(TC2),
`ifdef JK_MOD_COUNTER_SAT_EN
        .SAT(SAT2),
`endif
        .WRAP(WRAP2)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic       load, en, up;
        logic [3:0] d;
        logic [3:0] q;
        logic       tc, wrap;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic load, en, up, input logic [3:0] d,
                       input logic [3:0] q, input logic tc, wrap);
        vec_t v;
        v.load = load; v.en = en; v.up = up; v.d = d;
        v.q = q; v.tc = tc; v.wrap = wrap;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // drive inputs, take one edge, sample 1 time unit later
    task automatic step(input logic load, en, up, input logic [3:0] d);
        LOAD = load; EN = en; UP = up; D = d;
        @(posedge CLK);
        #1;
    endtask

    initial begin
        // reset state before any clock edge
        #1;
        chk("reset_q", 32'(Q), 0);
        chk("reset_wrap", 32'(WRAP), 0);
        chk("reset_q2", 32'(Q2), 0);
        #11 RST = 1'b0;   // released mid-cycle

`ifndef JK_MOD_COUNTER_SAT_EN
        // up count from 0: 1..9,0,1,2
        for (int i = 0; i < 12; i++) begin
            logic [3:0] q;
            q = 4'((i + 1) % 10);
            add(0, 1, 1, 0, q, q == 9, i == 9);
        end
        // down count from 2: 1,0,9,8
        add(0, 1, 0, 0, 1, 0, 0);
        add(0, 1, 0, 0, 0, 1, 0);
        add(0, 1, 0, 0, 9, 0, 1);
        add(0, 1, 0, 0, 8, 0, 0);
`endif
        // load and priority (valid in both builds)
        add(1, 1, 1, 6,  6, 0, 0);
        add(1, 0, 1, 13, 9, 1, 0);
        add(1, 1, 0, 15, 9, 0, 0);
        add(1, 0, 1, 4,  4, 0, 0);
        for (int i = 0; i < 5; i++) add(0, 0, 1, 0, 4, 0, 0);
        add(0, 1, 1, 0, 5, 0, 0);
        add(0, 1, 0, 0, 4, 0, 0);
        add(0, 1, 1, 0, 5, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].load, vecs[i].en, vecs[i].up, vecs[i].d);
            chk($sformatf("vec%0d_q", i),    32'(Q),    32'(vecs[i].q));
            chk($sformatf("vec%0d_tc", i),   32'(TC),   32'(vecs[i].tc));
            chk($sformatf("vec%0d_wrap", i), 32'(WRAP), 32'(vecs[i].wrap));
        end

        // asynchronous reset mid-cycle at Q=7, held across an enabled edge
        step(1, 0, 1, 7);
        chk("pre_rst_q", 32'(Q), 7);
        LOAD = 0; EN = 1; UP = 1;
        #3 RST = 1'b1;
        #1;
        chk("async_rst_q", 32'(Q), 0);
        chk("async_rst_wrap", 32'(WRAP), 0);
        @(posedge CLK);
        #1;
        chk("rst_hold_q", 32'(Q), 0);
        #3 RST = 1'b0;
        step(0, 1, 1, 0);
        chk("post_rst_q", 32'(Q), 1);

`ifndef JK_MOD_COUNTER_SAT_EN
        // reset discards a pending WRAP pulse
        step(1, 0, 1, 9);
        step(0, 1, 1, 0);
        chk("wrap_before_rst", 32'(WRAP), 1);
        EN = 0;
        #3 RST = 1'b1;
        #1;
        chk("rst_clears_wrap", 32'(WRAP), 0);
        #2 RST = 1'b0;

        // power-of-two modulus: natural binary wrap still pulses WRAP
        LOAD2 = 0; UP2 = 1; EN2 = 1;
        for (int i = 0; i < 9; i++) begin
            @(posedge CLK);
            #1;
            chk($sformatf("pow2_q%0d", i), 32'(Q2), 32'((i + 1) % 8));
            chk($sformatf("pow2_wrap%0d", i), 32'(WRAP2), 32'(i == 7));
        end
        EN2 = 0;
`else
        // saturation: 8 -> 9,9,9 then back down to 8
        step(1, 0, 1, 8);
        chk("sat_load_q", 32'(Q), 8);
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 1, 0);
            chk($sformatf("sat_q%0d", i), 32'(Q), 9);
            chk($sformatf("sat_flag%0d", i), 32'(SAT), 32'(i >= 1));
            chk($sformatf("sat_wrap%0d", i), 32'(WRAP), 0);
        end
        step(0, 1, 0, 0);
        chk("sat_down_q", 32'(Q), 8);
        chk("sat_down_flag", 32'(SAT), 0);
        // down-saturation at 0, released by LOAD
        step(1, 0, 0, 0);
        step(0, 1, 0, 0);
        chk("sat0_q", 32'(Q), 0);
        chk("sat0_flag", 32'(SAT), 1);
        step(1, 0, 0, 3);
        chk("sat_load_clr", 32'(SAT), 0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/jk_mod_counter.md
Name: jk_mod_counter

Overview:
- Synchronous modulo-MOD up/down counter built from a chain of JK-style storage cells.
- Each bit is driven by generated J/K commands: hold, set, reset or toggle.
- Sits directly downstream of single JK flip-flop cells. It is the consumer stage that turns per-bit J/K storage into a counted value, with terminal-count and wrap outputs for the next stage.

Parameters:
- W, 4, counter width in bits (2..16).
- MOD, 10, count modulus; legal range 2..2^W. Q counts 0..MOD-1.

Ports:
- CLK  input  1  rising-edge clock.
- RST  input  1  asynchronous, active-high reset.
- EN  input  1  count enable.
- UP  input  1  direction: 1 = increment, 0 = decrement.
- LOAD  input  1  synchronous parallel load; takes priority over EN.
- D  input  W  load value.
- Q  output  W  registered count.
- TC  output  1  combinational terminal count: UP & (Q==MOD-1), or ~UP & (Q==0).
- WRAP  output  1  registered one-cycle pulse; high in the cycle after a wrap occurred.

Behaviour:
- Reset: Q=0 and WRAP=0 immediately on RST rising, independent of CLK. Both hold while RST=1.
- Per-bit command: each Q[i] is updated on the CLK rising edge by a JK cell.
  - J=0,K=0: hold.
  - J=0,K=1: clear.
  - J=1,K=0: set.
  - J=1,K=1: toggle.
- Priority per edge: LOAD > EN > hold.
- LOAD=1:
  - Q <= D when D < MOD; Q <= MOD-1 when D >= MOD.
  - Each bit uses J=target bit, K=~target bit.
  - WRAP <= 0. EN and UP are ignored.
- EN=1, TC=0, UP=1: Q <= Q+1, via toggle of bit i when all lower bits are 1.
- EN=1, TC=0, UP=0: Q <= Q-1, via toggle of bit i when all lower bits are 0.
- EN=1, TC=1 (wrap):
  - UP=1: Q <= 0 (clear commands).
  - UP=0: Q <= MOD-1 (set/clear commands per bit).
  - WRAP <= 1 for exactly one cycle.
- EN=0, LOAD=0: all bits hold; WRAP <= 0.
- Latency: Q reflects a count, load or wrap one edge after the qualifying inputs.
- TC updates combinationally with Q and UP; direction changes take effect on the same edge.
- MOD == 2^W: natural binary wrap. The toggle-chain result equals the wrap value, and WRAP still pulses.
- UP toggled mid-count: there is no pipeline state, so the next edge uses the new direction.
- RST asserted mid-count or mid-load: the pending update is discarded. First update happens on the first CLK edge after RST deasserts.
- Reachable Q is always < MOD. Out-of-range Q is prevented by the load clamp.

Optional Feature:
- Macro: JK_MOD_COUNTER_SAT_EN.
- Defined: the counter saturates instead of wrapping.
  - EN=1 with TC=1 holds Q (J=K=0 on all bits).
  - WRAP stays 0.
  - A SAT output port (1 bit, registered) is added. It is set when a count request arrives at TC, and cleared by LOAD, by a count in the opposite direction, or by RST.
- Undefined: modulo wrap behaviour as above; no SAT port.

Decomposition:
- Package jk_pkg:
  - 2-bit JK command encoding constants: JK_HOLD=2'b00, JK_CLR=2'b01, JK_SET=2'b10, JK_TGL=2'b11.
  - Function mapping a target bit to a set/clear command.
- Sub-module jk_cell, instantiated W times:
  - Single-bit JK storage with async active-high RST.
  - Hold/clear/set/toggle semantics per the command table.
- Top level: command generation, TC/WRAP logic and load clamp.

Test Plan (W=4, MOD=10):
- Reset: RST pulse mid-clock with Q=7 -> Q=0 and WRAP=0 before the next CLK edge; Q remains 0 while RST=1.
- Up count: EN=1, UP=1 from 0 for 12 edges -> Q sequence 1..9,0,1,2. TC high while Q=9. WRAP high only in the cycle after the 9->0 edge.
- Down count: EN=1, UP=0 from 2 -> Q sequence 1,0,9,8. TC high while Q=0. One WRAP pulse after the 0->9 edge.
- Load and priority:
  - LOAD=1, D=6, EN=1 -> Q=6, WRAP=0.
  - LOAD=1, D=13 -> Q=9.
  - LOAD=1, D=15 with UP=0 -> Q=9.
- Hold and direction change:
  - EN=0 for 5 edges at Q=4 -> Q stays 4.
  - Then EN=1 with UP alternating 1,0,1 -> Q sequence 5,4,5.
- SAT build (JK_MOD_COUNTER_SAT_EN defined):
  - Count up from 8 for 3 edges -> Q sequence 9,9,9; SAT=1 from the 2nd edge; WRAP stays 0.
  - Then UP=0 -> Q=8, SAT=0.
